mux5_bus_arbiter: RTL and testbench

//   Round-robin arbiter that shares the 32-bit 5-to-1 one-hot bus mux between five requesters.
//   - Grants the bus to one master at a time.
//   - Drives the mux select directly in the mux's one-hot encoding.
//   - Enforces a one-cycle turnaround between owners.

---
 rtl/mux5_bus_arbiter.sv | 147 ++++++++++++++
 tb/tb_mux5_bus_arbiter.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/mux5_bus_arbiter.sv
// Round-robin arbiter for five masters sharing a 32-bit one-hot 5:1 bus mux, with a one-cycle turnaround between owners.
// Optional forced release after MAX_HOLD cycles under contention: enable with `define ARB_TIMEOUT_EN.
module mux5_bus_arbiter #(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 5
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [4:0] req,
    output logic [4:0] grant,
    output logic [4:0] mux_sel,
    output logic       busy,
    output logic [2:0] owner
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Reject a configuration where the hold counter cannot reach MAX_HOLD-1.
    if ((MAX_HOLD < 2) || (MAX_HOLD > (1 << CNT_W))) begin : g_bad_cfg
        $error("mux5_bus_arbiter: MAX_HOLD out of range for CNT_W");
    end

    // Scan last+1, last+2, ... (mod 5); result is {found, index}.
    function automatic logic [3:0] rr_pick(input logic [4:0] r, input logic [2:0] last);
        logic [3:0] res;
        logic [2:0] idx;
        res = 4'b0000;
        idx = last;
        for (int k = 0; k < 5; k++) begin
            idx = (idx == 3'd4) ? 3'd0 : idx + 3'd1;
            if ((res[3] == 1'b0) && r[idx]) begin
                res = {1'b1, idx};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    state_t     state_r, state_s;
    logic [4:0] grant_r, grant_s;
    logic [2:0] owner_r, owner_s;
    logic       busy_r, busy_s;
    logic [2:0] last_owner_r, last_owner_s;
    logic [3:0] pick_s;

`ifdef ARB_TIMEOUT_EN
    logic [CNT_W-1:0] hold_cnt_r, hold_cnt_s;
    logic             evict_s;
`endif

    assign pick_s = rr_pick(req, last_owner_r);

`ifdef ARB_TIMEOUT_EN
    // Forced release only when the owner has used its full window and someone else is waiting.
    always_comb begin
        evict_s = (hold_cnt_r == CNT_W'(MAX_HOLD - 1)) && ((req & ~grant_r) != 5'b00000);
    end
`endif

    // Next-state and next-output logic for the IDLE/GRANT arbiter.
    always_comb begin
        state_s      = state_r;
        grant_s      = grant_r;
        owner_s      = owner_r;
        busy_s       = busy_r;
        last_owner_s = last_owner_r;
`ifdef ARB_TIMEOUT_EN
        hold_cnt_s   = hold_cnt_r;
`endif
        case (state_r)
            IDLE: begin
                if (pick_s[3]) begin
                    state_s = GRANT;
                    grant_s = 5'b00001 << pick_s[2:0];
                    owner_s = pick_s[2:0];
                    busy_s  = 1'b1;
`ifdef ARB_TIMEOUT_EN
                    hold_cnt_s = {CNT_W{1'b0}};
`endif
                end else begin
                    state_s = IDLE;
                end
            end
            GRANT: begin
`ifdef ARB_TIMEOUT_EN
                if (req[owner_r] && !evict_s) begin
                    state_s = GRANT;
                    if (hold_cnt_r != {CNT_W{1'b1}}) begin
                        hold_cnt_s = hold_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    end else begin
                        hold_cnt_s = hold_cnt_r;
                    end
                end else begin
`else
                if (req[owner_r]) begin
                    state_s = GRANT;
                end else begin
`endif
                    // Release always passes through IDLE, giving the bus turnaround cycle.
                    state_s      = IDLE;
                    grant_s      = 5'b00000;
                    busy_s       = 1'b0;
                    last_owner_s = owner_r;
                end
            end
            default: begin
                state_s = IDLE;
                grant_s = 5'b00000;
                busy_s  = 1'b0;
            end
        endcase
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= IDLE;
            grant_r      <= 5'b00000;
            owner_r      <= 3'd0;
            busy_r       <= 1'b0;
            last_owner_r <= 3'd4;
`ifdef ARB_TIMEOUT_EN
            hold_cnt_r   <= {CNT_W{1'b0}};
`endif
        end else begin
            state_r      <= state_s;
            grant_r      <= grant_s;
            owner_r      <= owner_s;
            busy_r       <= busy_s;
            last_owner_r <= last_owner_s;
`ifdef ARB_TIMEOUT_EN
            hold_cnt_r   <= hold_cnt_s;
`endif
        end
    end

    assign grant   = grant_r;
    assign owner   = owner_r;
    assign busy    = busy_r;
    // The mux orders its one-hot select MSB-first: master 0 drives bit 4.
    assign mux_sel = {grant_r[0], grant_r[1], grant_r[2], grant_r[3], grant_r[4]};

endmodule

// File: tb/tb_mux5_bus_arbiter.sv
// Directed bench for mux5_bus_arbiter: reset, round-robin, single master, withdraw, async reset, timeout, invariants.
module tb_mux5_bus_arbiter;

    logic       clk;
    logic       reset_n;
    logic [4:0] req;
    logic [4:0] grant;
    logic [4:0] mux_sel;
    logic       busy;
    logic [2:0] owner;

    int passed = 0;
    int total  = 0;

    mux5_bus_arbiter #(.MAX_HOLD(4), .CNT_W(5)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req),
        .grant   (grant),
        .mux_sel (mux_sel),
        .busy    (busy),
        .owner   (owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_out(input string tag, input logic [4:0] g, input logic [4:0] m,
                             input logic b);
        check({tag, ".grant"}, {27'd0, grant}, {27'd0, g});
        check({tag, ".mux_sel"}, {27'd0, mux_sel}, {27'd0, m});
        check({tag, ".busy"}, {31'd0, busy}, {31'd0, b});
    endtask

    logic       prev_busy = 1'b0;
    logic [2:0] prev_owner = 3'd0;

    // Per-cycle invariants sampled away from the active edge.
    always @(negedge clk) begin
        if (reset_n) begin
            check("inv.onehot0", {31'd0, $onehot0(grant)}, 32'd1);
            check("inv.mux_rev", {27'd0, mux_sel},
                  {27'd0, grant[0], grant[1], grant[2], grant[3], grant[4]});
            check("inv.busy", {31'd0, busy}, {31'd0, |grant});
            if (prev_busy && busy) begin
                check("inv.owner_stable", {29'd0, owner}, {29'd0, prev_owner});
            end
        end
        prev_busy  = busy;
        prev_owner = owner;
    end

    initial begin
        reset_n = 1'b0;
        req     = 5'b11111;

        // 1. Reset with all requesting.
        @(negedge clk);
        @(negedge clk);
        check_out("reset", 5'b00000, 5'b00000, 1'b0);
        check("reset.owner", {29'd0, owner}, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check_out("first_grant", 5'b00001, 5'b10000, 1'b1);
        check("first_grant.owner", {29'd0, owner}, 32'd0);

        // 2. Round-robin 0,1,2,3,4,0 with a turnaround cycle between owners.
        for (int i = 0; i < 6; i++) begin
            int o;
            o = i % 5;
            check($sformatf("rr%0d.g1", i), {27'd0, grant}, 32'd1 << o);
            check($sformatf("rr%0d.owner", i), {29'd0, owner}, o);
            @(negedge clk);
            check($sformatf("rr%0d.g2", i), {27'd0, grant}, 32'd1 << o);
            @(negedge clk);
            check($sformatf("rr%0d.g3", i), {27'd0, grant}, 32'd1 << o);
            req[o] = 1'b0;
            @(negedge clk);
            check_out($sformatf("rr%0d.gap", i), 5'b00000, 5'b00000, 1'b0);
            req[o] = 1'b1;
            @(negedge clk);
        end
        check("rr_after.owner", {29'd0, owner}, 32'd1);
        req = 5'b00000;
        @(negedge clk);
        check_out("rr_idle", 5'b00000, 5'b00000, 1'b0);
        @(negedge clk);

        // 3. Single master 3 for four cycles.
        req = 5'b01000;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check_out($sformatf("single.c%0d", c), 5'b01000, 5'b00010, 1'b1);
            check($sformatf("single.owner%0d", c), {29'd0, owner}, 32'd3);
        end
        req = 5'b00000;
        @(negedge clk);
        check_out("single.end", 5'b00000, 5'b00000, 1'b0);

        // 4a. Master 2 raises and withdraws while master 1 owns the bus.
        req = 5'b00010;
        @(negedge clk);
        check_out("wd.m1", 5'b00010, 5'b01000, 1'b1);
        req = 5'b00110;
        @(negedge clk);
        check_out("wd.ignored", 5'b00010, 5'b01000, 1'b1);
        req = 5'b00010;
        @(negedge clk);
        check_out("wd.still_m1", 5'b00010, 5'b01000, 1'b1);
        req = 5'b00000;
        @(negedge clk);
        check_out("wd.release", 5'b00000, 5'b00000, 1'b0);
        @(negedge clk);
        check_out("wd.no_m2", 5'b00000, 5'b00000, 1'b0);

        // 4b. Asynchronous reset while busy.
        req = 5'b00001;
        @(negedge clk);
        check_out("mid.busy", 5'b00001, 5'b10000, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        check_out("mid.async", 5'b00000, 5'b00000, 1'b0);
        req = 5'b00000;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check_out("mid.after", 5'b00000, 5'b00000, 1'b0);

        // 5. Master 0 holds while master 1 waits.
        req = 5'b00011;
        for (int c = 0; c < 6; c++) begin
            logic [4:0] exp_g;
            @(negedge clk);
`ifdef ARB_TIMEOUT_EN
            exp_g = (c < 4) ? 5'b00001 : ((c == 4) ? 5'b00000 : 5'b00010);
`else
            exp_g = 5'b00001;
`endif
            check($sformatf("timeout.c%0d", c), {27'd0, grant}, {27'd0, exp_g});
        end
        req = 5'b00000;
        @(negedge clk);
        @(negedge clk);
        check_out("final_idle", 5'b00000, 5'b00000, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
